// File: rtl/line_buffer_ctrl.sv
// line_buffer_ctrl: sequences the WIN-1 line-buffer shift chain feeding the ORB patch window.
// Optional feature macro LBC_SYNC_ERR_EN adds a sticky sync_err_o flag for frame-sync faults.
module line_buffer_ctrl #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int WIN   = 31,
  parameter int CW    = 10,
  parameter int RW    = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid_i,
  input  logic          in_sof_i,
  output logic          in_ready_o,
  input  logic          out_ready_i,
  output logic          sr_ena_o,
  output logic          sr_rst_o,
  output logic          win_valid_o,
  output logic [CW-1:0] col_o,
  output logic [RW-1:0] row_o,
  output logic          frame_done_o,
`ifdef LBC_SYNC_ERR_EN
  output logic          busy_o,
  output logic          sync_err_o
`else
  output logic          busy_o
`endif
);

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_WIN  = CW'(WIN - 1);
  localparam logic [RW-1:0] ROW_WIN  = RW'(WIN - 1);

  state_t        state_q;
  logic [CW-1:0] col_q, ncol_q, ncol_d, cur_col;
  logic [RW-1:0] row_q, nrow_q, nrow_d, cur_row;
  logic          win_valid_q, frame_done_q, sr_rst_q;
`ifdef LBC_SYNC_ERR_EN
  logic          sync_err_q;
`endif

  logic in_ready, sync_ok, in_frame;
  logic accept, shift, abort, drop;
  logic col_wrap, last_px, win_hit, fill_done;

  // Handshake: a pixel is accepted on valid&ready, but only shifted when it
  // is consistent with frame sync (sof opens a frame, sof inside a frame aborts).
  always_comb begin
    in_ready = 1'b0;
    sync_ok  = 1'b0;
    in_frame = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        sync_ok  = in_sof_i;
      end
      FILL: begin
        in_ready = 1'b1;
        sync_ok  = ~in_sof_i;
        in_frame = 1'b1;
      end
      RUN: begin
        in_ready = out_ready_i;
        sync_ok  = ~in_sof_i;
        in_frame = 1'b1;
      end
      default: ;
    endcase
  end

  assign accept = in_valid_i & in_ready;
  assign shift  = accept & sync_ok;
  assign abort  = accept & in_sof_i & in_frame;
  assign drop   = accept & ~in_sof_i & (state_q == IDLE);

  // The sof pixel is always (0,0); inside a frame the next-position counters apply.
  assign cur_col   = in_frame ? ncol_q : '0;
  assign cur_row   = in_frame ? nrow_q : '0;
  assign col_wrap  = (cur_col == COL_LAST);
  assign last_px   = col_wrap && (cur_row == ROW_LAST);
  assign win_hit   = in_frame && (cur_col >= COL_WIN) && (cur_row >= ROW_WIN);
  assign fill_done = (cur_col == COL_WIN) && (cur_row == ROW_WIN);

  always_comb begin
    ncol_d = col_wrap ? '0 : cur_col + CW'(1);
    nrow_d = cur_row;
    if (col_wrap) begin
      nrow_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
    end
  end

  // Registered state, position and pulse outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      ncol_q       <= '0;
      nrow_q       <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      sr_rst_q     <= 1'b1;
`ifdef LBC_SYNC_ERR_EN
      sync_err_q   <= 1'b0;
`endif
    end else begin
      win_valid_q  <= shift & win_hit;
      frame_done_q <= 1'b0;
      sr_rst_q     <= 1'b0;
`ifdef LBC_SYNC_ERR_EN
      if (abort || drop) begin
        sync_err_q <= 1'b1;
      end
`endif
      if (shift) begin
        col_q  <= cur_col;
        row_q  <= cur_row;
        ncol_q <= ncol_d;
        nrow_q <= nrow_d;
      end
      case (state_q)
        IDLE: begin
          if (shift) begin
            state_q <= FILL;
          end
        end
        FILL, RUN: begin
          if (abort || (shift && last_px)) begin
            state_q      <= FLUSH;
            sr_rst_q     <= 1'b1;
            frame_done_q <= 1'b1;
          end else if (shift && fill_done && (state_q == FILL)) begin
            state_q <= RUN;
          end
        end
        FLUSH: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready_o   = in_ready;
  assign sr_ena_o     = shift;
  assign sr_rst_o     = sr_rst_q;
  assign win_valid_o  = win_valid_q;
  assign col_o        = col_q;
  assign row_o        = row_q;
  assign frame_done_o = frame_done_q;
  assign busy_o       = (state_q != IDLE);
`ifdef LBC_SYNC_ERR_EN
  assign sync_err_o   = sync_err_q;
`endif

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// tb_line_buffer_ctrl: directed bench for line_buffer_ctrl on an 8x6 image with a 3x3 window.
// Honours LBC_SYNC_ERR_EN when the design is built with it.
module tb_line_buffer_ctrl;
  localparam int IMG_W = 8;
  localparam int IMG_H = 6;
  localparam int WIN   = 3;
  localparam int CW    = 3;
  localparam int RW    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic          out_ready = 1'b1;
  logic          in_ready, sr_ena, sr_rst, win_valid, frame_done, busy;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
`ifdef LBC_SYNC_ERR_EN
  logic          sync_err;
`endif

  line_buffer_ctrl #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .WIN(WIN), .CW(CW), .RW(RW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .in_sof_i    (in_sof),
    .in_ready_o  (in_ready),
    .out_ready_i (out_ready),
    .sr_ena_o    (sr_ena),
    .sr_rst_o    (sr_rst),
    .win_valid_o (win_valid),
    .col_o       (col),
    .row_o       (row),
    .frame_done_o(frame_done),
`ifdef LBC_SYNC_ERR_EN
    .busy_o      (busy),
    .sync_err_o  (sync_err)
`else
    .busy_o      (busy)
`endif
  );

  always #5 clk = ~clk;

  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Event monitor on the falling edge
  int   ena_cnt = 0, win_cnt = 0, fd_cnt = 0, srr_cnt = 0, fd_ena = 0;
  logic fd_srr = 1'b0, fd_prev = 1'b0, ena_prev = 1'b0;
  int   win_idx [256];

  always @(negedge clk) begin
    if (win_valid) begin
      win_idx[win_cnt & 255] <= ena_cnt - 1;
      win_cnt <= win_cnt + 1;
    end
    if (frame_done) begin
      fd_ena  <= ena_cnt;
      fd_srr  <= sr_rst;
      fd_prev <= ena_prev;
      fd_cnt  <= fd_cnt + 1;
    end
    if (sr_rst) srr_cnt <= srr_cnt + 1;
    if (sr_ena) ena_cnt <= ena_cnt + 1;
    ena_prev <= sr_ena;
  end

  logic          s_rdy, s_ena, s_srr, s_busy, s_win, s_fd;
  logic [CW-1:0] s_col;
  logic [RW-1:0] s_row;

  task automatic cyc(input logic v, input logic s, input logic o);
    in_valid  = v;
    in_sof    = s;
    out_ready = o;
    @(negedge clk);
    s_rdy  = in_ready;
    s_ena  = sr_ena;
    s_srr  = sr_rst;
    s_busy = busy;
    s_win  = win_valid;
    s_fd   = frame_done;
    s_col  = col;
    s_row  = row;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b1);
  endtask

  // Offers pixels 0..n-1 (sof on pixel 0 and on abort_at), stalling 5 cycles at bp_at
  task automatic run_frame(input int n, input int abort_at, input int bp_at);
    int   p       = 0;
    int   guard   = 0;
    int   bp_left = 5;
    logic s;
    while (p < n && guard < 400) begin
      guard++;
      s = (p == 0) || (p == abort_at);
      if (p == bp_at && bp_left > 0) begin
        cyc(1'b1, s, 1'b0);
        bp_left--;
        chk("bp_in_ready", s_rdy, 0);
        chk("bp_sr_ena", s_ena, 0);
        chk("bp_col", s_col, (bp_at - 1) % IMG_W);
        chk("bp_row", s_row, (bp_at - 1) / IMG_W);
      end else begin
        cyc(1'b1, s, 1'b1);
        if (p == abort_at) begin
          chk("abort_sr_ena", s_ena, 0);
          p = n;
        end else if (s_ena) begin
          p++;
        end
      end
    end
    chk("frame_progress", (p >= n), 1);
  endtask

  int e0, w0, f0, r0;

  task automatic snap();
    e0 = ena_cnt;
    w0 = win_cnt;
    f0 = fd_cnt;
    r0 = srr_cnt;
  endtask

  task automatic check_full(input string tag);
    chk({tag, "_ena"}, ena_cnt - e0, 48);
    chk({tag, "_win"}, win_cnt - w0, 24);
    chk({tag, "_first_win_px"}, win_idx[w0 & 255] - e0, 18);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    cyc(1'b0, 1'b0, 1'b1);
    chk("rst_sr_rst_hold", s_srr, 1);
    chk("rst_win_valid", s_win, 0);
    chk("rst_frame_done", s_fd, 0);
    chk("rst_col", s_col, 0);
    chk("rst_row", s_row, 0);
    chk("rst_busy", s_busy, 0);
    chk("rst_sr_ena", s_ena, 0);
    chk("rst_in_ready", s_rdy, 1);
    cyc(1'b0, 1'b0, 1'b1);
    chk("rst_sr_rst_release", s_srr, 0);

    // Full frame with continuous valid
    snap();
    run_frame(48, -1, -1);
    cyc(1'b0, 1'b0, 1'b1);
    chk("ff_flush_col", s_col, 7);
    chk("ff_flush_row", s_row, 5);
    chk("ff_flush_sr_rst", s_srr, 1);
    chk("ff_flush_busy", s_busy, 1);
    chk("ff_flush_in_ready", s_rdy, 0);
    idle(4);
    check_full("ff");
    chk("ff_fd_count", fd_cnt - f0, 1);
    chk("ff_fd_after_px", fd_ena - e0, 48);
    chk("ff_fd_with_sr_rst", fd_srr, 1);
    chk("ff_fd_one_after_last", fd_prev, 1);
    chk("ff_sr_rst_pulses", srr_cnt - r0, 1);
    chk("ff_idle_busy", s_busy, 0);
`ifdef LBC_SYNC_ERR_EN
    chk("ff_sync_err", sync_err, 0);
`endif

    // Backpressure in RUN
    snap();
    run_frame(48, -1, 25);
    idle(5);
    check_full("bp");

    // Mid-frame sof abort at pixel 20
    snap();
    run_frame(48, 20, -1);
    chk("ab_ena", ena_cnt - e0, 20);
    cyc(1'b0, 1'b0, 1'b1);
    chk("ab_flush_sr_rst", s_srr, 1);
    chk("ab_flush_busy", s_busy, 1);
    chk("ab_flush_in_ready", s_rdy, 0);
    chk("ab_col", s_col, 3);
    chk("ab_row", s_row, 2);
    cyc(1'b0, 1'b0, 1'b1);
    chk("ab_idle_sr_rst", s_srr, 0);
    chk("ab_idle_busy", s_busy, 0);
`ifdef LBC_SYNC_ERR_EN
    chk("ab_sync_err", sync_err, 1);
`endif
    snap();
    run_frame(48, -1, -1);
    idle(5);
    check_full("ab_next");

    // Reset in the middle of a frame
    run_frame(30, -1, -1);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_sof   = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b1);
    chk("mr_sr_rst", s_srr, 1);
    chk("mr_col", s_col, 0);
    chk("mr_row", s_row, 0);
    chk("mr_busy", s_busy, 0);
    chk("mr_win_valid", s_win, 0);
`ifdef LBC_SYNC_ERR_EN
    chk("mr_sync_err", sync_err, 0);
`endif

    // Pixels without sof while idle are dropped
    snap();
    repeat (4) cyc(1'b1, 1'b0, 1'b1);
    idle(1);
    chk("dr_ena", ena_cnt - e0, 0);
    chk("dr_col", s_col, 0);
    chk("dr_row", s_row, 0);
    chk("dr_busy", s_busy, 0);
`ifdef LBC_SYNC_ERR_EN
    chk("dr_sync_err", sync_err, 1);
`endif
    snap();
    run_frame(48, -1, -1);
    idle(5);
    check_full("dr_next");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
